// File: rtl/mux_arr_reg_param_module.sv
// -----------------------------------------------------------------------------
// mux_arr_reg_param_module
//
// Registered N:1 array multiplexer with a valid/ready output handshake.
// It has two modes. Direct mode returns one beat from the channel named by
// sel. Auto-scan mode streams channels 0..CHANNELS-1 in order, one beat per
// accepted transfer.
//
// Parameters:
//   WIDTH     bit width of each channel
//   CHANNELS  number of input channels (>= 2, any value)
//   SEL_W     derived channel-index width, $clog2(CHANNELS)
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in         packed channels, channel k = in[k*WIDTH +: WIDTH]
//   sel        channel index for direct mode
//   mode       0 = direct select, 1 = auto-scan
//   req_valid  request strobe
//   req_ready  high in IDLE; a request is accepted on req_valid && req_ready
//   out        registered selected data
//   out_chan   channel index of the current out
//   out_valid  out/out_chan hold a beat
//   out_ready  consumer accepts the current beat
//   done       high in the cycle the last scan beat is accepted
//   sel_err    sticky: direct request with sel >= CHANNELS
//
// Optional feature (macro MUX_ARR_PARITY_EN):
//   in_par     one parity bit per channel
//   out_par    registered ^out
//   par_err    sticky: a sampled channel disagreed with its in_par bit
// -----------------------------------------------------------------------------
module mux_arr_reg_param_module #(
  parameter  int WIDTH    = 2,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  input  logic                      req_valid,
  output logic                      req_ready,
  output logic [WIDTH-1:0]          out,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      done,
  output logic                      sel_err
`ifdef MUX_ARR_PARITY_EN
  ,
  input  logic [CHANNELS-1:0]       in_par,
  output logic                      out_par,
  output logic                      par_err
`endif
);

  // The channel array is padded up to a power of two so any sel value indexes
  // a real entry; the padding reads as zero, which gives the required out=0
  // for an out-of-range direct select without a separate bounds mux.
  localparam int                PAD      = 1 << SEL_W;
  localparam logic [SEL_W-1:0]  LAST_IDX = SEL_W'(CHANNELS - 1);
  localparam logic [SEL_W:0]    CHAN_CNT = (SEL_W + 1)'(CHANNELS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } stateT;

  stateT             stateReg;
  stateT             stateNext;
  logic [SEL_W-1:0]  idxReg;
  logic [SEL_W-1:0]  idxNext;
  logic [WIDTH-1:0]  outReg;
  logic [SEL_W-1:0]  outChanReg;
  logic              selErrReg;

  // One beat is captured per sampleEn; sampleIdx names the channel captured.
  logic              sampleEn;
  logic [SEL_W-1:0]  sampleIdx;
  logic              selErrSet;

  logic [WIDTH-1:0]  chanArr [PAD];

  genvar gi;
  generate
    for (gi = 0; gi < PAD; gi++) begin : gChan
      if (gi < CHANNELS) begin : gReal
        assign chanArr[gi] = in[gi*WIDTH +: WIDTH];
      end else begin : gZero
        assign chanArr[gi] = '0;
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Next-state / control
  // ---------------------------------------------------------------------------
  always_comb begin
    stateNext = stateReg;
    idxNext   = idxReg;
    sampleEn  = 1'b0;
    sampleIdx = idxReg;
    selErrSet = 1'b0;
    done      = 1'b0;

    case (stateReg)
      IDLE: begin
        if (req_valid) begin
          sampleEn = 1'b1;
          if (mode) begin
            idxNext   = '0;
            sampleIdx = '0;
            stateNext = SCAN;
          end else begin
            sampleIdx = sel;
            selErrSet = ({1'b0, sel} >= CHAN_CNT);
            stateNext = HOLD;
          end
        end
      end

      HOLD: begin
        if (out_ready) begin
          stateNext = IDLE;
        end
      end

      SCAN: begin
        if (out_ready) begin
          if (idxReg == LAST_IDX) begin
            // done is combinational so it coincides with the final beat's
            // transfer; idx stays at the last channel rather than wrapping.
            done      = 1'b1;
            stateNext = IDLE;
          end else begin
            // Load the following channel in the same edge that retires the
            // current beat, so a scan with out_ready held high has no bubble.
            idxNext   = idxReg + 1'b1;
            sampleIdx = idxReg + 1'b1;
            sampleEn  = 1'b1;
          end
        end
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg   <= IDLE;
      idxReg     <= '0;
      outReg     <= '0;
      outChanReg <= '0;
      selErrReg  <= 1'b0;
    end else begin
      stateReg <= stateNext;
      idxReg   <= idxNext;
      if (sampleEn) begin
        outReg     <= chanArr[sampleIdx];
        outChanReg <= sampleIdx;
      end
      if (selErrSet) begin
        selErrReg <= 1'b1;
      end
    end
  end

`ifdef MUX_ARR_PARITY_EN
  // ---------------------------------------------------------------------------
  // Parity: checked against the same channel captured into out, at the same
  // edge. Padding entries count as consistent because they carry no source.
  // ---------------------------------------------------------------------------
  logic [PAD-1:0] chanParOk;
  logic           outParReg;
  logic           parErrReg;

  generate
    for (gi = 0; gi < PAD; gi++) begin : gPar
      if (gi < CHANNELS) begin : gReal
        assign chanParOk[gi] = (in_par[gi] == ^in[gi*WIDTH +: WIDTH]);
      end else begin : gZero
        assign chanParOk[gi] = 1'b1;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outParReg <= 1'b0;
      parErrReg <= 1'b0;
    end else if (sampleEn) begin
      outParReg <= ^chanArr[sampleIdx];
      if (!chanParOk[sampleIdx]) begin
        parErrReg <= 1'b1;
      end
    end
  end

  assign out_par = outParReg;
  assign par_err = parErrReg;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign req_ready = (stateReg == IDLE);
  assign out_valid = (stateReg != IDLE);
  assign out       = outReg;
  assign out_chan  = outChanReg;
  assign sel_err   = selErrReg;

endmodule

// File: tb/tb_mux_arr_reg_param_module.sv
// -----------------------------------------------------------------------------
// Testbench for mux_arr_reg_param_module.
// Two instances: a default 4-channel x 2-bit mux, and a 3-channel x 8-bit mux
// that exercises the out-of-range select. Inputs are driven and outputs
// sampled on the falling clock edge. Parity checks exist when
// MUX_ARR_PARITY_EN is defined.
// -----------------------------------------------------------------------------
module tb_mux_arr_reg_param_module;

  logic clk;
  logic rst_n;

  // 4 channels x 2 bits
  logic [7:0]  in4;
  logic [1:0]  sel4;
  logic        mode4;
  logic        reqValid4;
  logic        reqReady4;
  logic [1:0]  out4;
  logic [1:0]  outChan4;
  logic        outValid4;
  logic        outReady4;
  logic        done4;
  logic        selErr4;

  // 3 channels x 8 bits
  logic [23:0] in3;
  logic [1:0]  sel3;
  logic        mode3;
  logic        reqValid3;
  logic        reqReady3;
  logic [7:0]  out3;
  logic [1:0]  outChan3;
  logic        outValid3;
  logic        outReady3;
  logic        done3;
  logic        selErr3;

`ifdef MUX_ARR_PARITY_EN
  logic [3:0]  inPar4;
  logic        outPar4;
  logic        parErr4;
  logic [2:0]  inPar3;
  logic        outPar3;
  logic        parErr3;
`endif

  int total = 0;
  int bad   = 0;

  mux_arr_reg_param_module #(.WIDTH(2), .CHANNELS(4)) u4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in4),
    .sel       (sel4),
    .mode      (mode4),
    .req_valid (reqValid4),
    .req_ready (reqReady4),
    .out       (out4),
    .out_chan  (outChan4),
    .out_valid (outValid4),
    .out_ready (outReady4),
    .done      (done4),
    .sel_err   (selErr4)
`ifdef MUX_ARR_PARITY_EN
    ,
    .in_par    (inPar4),
    .out_par   (outPar4),
    .par_err   (parErr4)
`endif
  );

  mux_arr_reg_param_module #(.WIDTH(8), .CHANNELS(3)) u3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in3),
    .sel       (sel3),
    .mode      (mode3),
    .req_valid (reqValid3),
    .req_ready (reqReady3),
    .out       (out3),
    .out_chan  (outChan3),
    .out_valid (outValid3),
    .out_ready (outReady3),
    .done      (done3),
    .sel_err   (selErr3)
`ifdef MUX_ARR_PARITY_EN
    ,
    .in_par    (inPar3),
    .out_par   (outPar3),
    .par_err   (parErr3)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Stall-phase values for in: none of them may leak into the held beat.
  logic [7:0] stallIn [3];
  logic [7:0] scan3Exp [3];

  initial begin
    stallIn  = '{8'h1B, 8'hFF, 8'h00};
    scan3Exp = '{8'hA1, 8'hB2, 8'hC3};

    clk       = 1'b0;
    rst_n     = 1'b0;
    in4       = 8'hE4;          // ch3..ch0 = 11, 10, 01, 00
    sel4      = '0;
    mode4     = 1'b0;
    reqValid4 = 1'b0;
    outReady4 = 1'b0;
    in3       = {8'hC3, 8'hB2, 8'hA1};
    sel3      = '0;
    mode3     = 1'b0;
    reqValid3 = 1'b0;
    outReady3 = 1'b0;
`ifdef MUX_ARR_PARITY_EN
    inPar4    = 4'b0110;        // correct parity of 11,10,01,00
    inPar3    = 3'b001;         // correct parity of C3,B2,A1
`endif

    // ---------------- reset state ----------------
    #12;
    chk("rst_valid",    32'(outValid4), 0);
    chk("rst_out",      32'(out4),      0);
    chk("rst_chan",     32'(outChan4),  0);
    chk("rst_done",     32'(done4),     0);
    chk("rst_selerr",   32'(selErr4),   0);
    chk("rst_ready",    32'(reqReady4), 1);
    chk("rst_selerr3",  32'(selErr3),   0);
`ifdef MUX_ARR_PARITY_EN
    chk("rst_outpar",   32'(outPar4),   0);
    chk("rst_parerr",   32'(parErr4),   0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ---------------- direct select, sel=2 ----------------
    mode4 = 1'b0; sel4 = 2'd2; reqValid4 = 1'b1; outReady4 = 1'b1;
    chk("d2_ready_idle", 32'(reqReady4), 1);
    chk("d2_valid_idle", 32'(outValid4), 0);
    tick();
    reqValid4 = 1'b0;
    $display("txn direct sel=2 out=%0h chan=%0d", out4, outChan4);
    chk("d2_out",    32'(out4),      2);
    chk("d2_chan",   32'(outChan4),  2);
    chk("d2_valid",  32'(outValid4), 1);
    chk("d2_busy",   32'(reqReady4), 0);
    chk("d2_done",   32'(done4),     0);
`ifdef MUX_ARR_PARITY_EN
    chk("d2_outpar", 32'(outPar4),   1);
`endif
    tick();
    chk("d2_valid_drop", 32'(outValid4), 0);
    chk("d2_out_keep",   32'(out4),      2);
    chk("d2_ready_back", 32'(reqReady4), 1);
    // out_ready while idle must not produce a beat
    tick();
    chk("idle_ready_ignored", 32'(outValid4), 0);

    // ---------------- direct hold with stalled consumer ----------------
    outReady4 = 1'b0; mode4 = 1'b0; sel4 = 2'd1; reqValid4 = 1'b1;
    tick();
    $display("txn direct sel=1 out=%0h chan=%0d", out4, outChan4);
    // a second request while busy must be ignored
    mode4 = 1'b1; sel4 = 2'd3;
    tick();
    chk("hold_out",   32'(out4),      1);
    chk("hold_chan",  32'(outChan4),  1);
    chk("hold_valid", 32'(outValid4), 1);
    reqValid4 = 1'b0; outReady4 = 1'b1;
    tick();
    chk("hold_release", 32'(outValid4), 0);

    // ---------------- full scan, out_ready held high ----------------
    mode4 = 1'b1; reqValid4 = 1'b1; outReady4 = 1'b1;
    tick();
    reqValid4 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      $display("txn scan beat=%0d out=%0h chan=%0d done=%0d", k, out4, outChan4, done4);
      chk("scan_out",   32'(out4),      32'(k));
      chk("scan_chan",  32'(outChan4),  32'(k));
      chk("scan_valid", 32'(outValid4), 1);
      chk("scan_done",  32'(done4),     (k == 3) ? 1 : 0);
      tick();
    end
    chk("scan_end_valid", 32'(outValid4), 0);
    chk("scan_end_done",  32'(done4),     0);
    chk("scan_end_ready", 32'(reqReady4), 1);

    // ---------------- scan with 3-cycle stall on ch1 ----------------
    mode4 = 1'b1; reqValid4 = 1'b1;
    tick();
    reqValid4 = 1'b0;
    chk("stall_ch0", 32'(out4), 0);
    tick();
    outReady4 = 1'b0;
    for (int s = 0; s < 3; s++) begin
      chk("stall_out",   32'(out4),      1);
      chk("stall_chan",  32'(outChan4),  1);
      chk("stall_valid", 32'(outValid4), 1);
      in4 = stallIn[s];
      tick();
    end
    chk("stall_out_last", 32'(out4), 1);
    $display("txn scan stall held out=%0h chan=%0d", out4, outChan4);
    in4 = 8'hE4; outReady4 = 1'b1;
    tick();
    chk("stall_resume_out",  32'(out4),     2);
    chk("stall_resume_chan", 32'(outChan4), 2);
    tick();
    chk("stall_last_out",  32'(out4),  3);
    chk("stall_last_done", 32'(done4), 1);
    tick();
    chk("stall_end_valid", 32'(outValid4), 0);

    // ---------------- asynchronous reset mid-scan ----------------
    mode4 = 1'b1; reqValid4 = 1'b1;
    tick();
    reqValid4 = 1'b0;
    tick();
    tick();
    chk("ar_pre_out", 32'(out4), 2);
    #2;
    rst_n = 1'b0;
    #1;
    $display("txn async reset mid-scan out=%0h valid=%0d", out4, outValid4);
    chk("ar_valid", 32'(outValid4), 0);
    chk("ar_out",   32'(out4),      0);
    chk("ar_chan",  32'(outChan4),  0);
    chk("ar_done",  32'(done4),     0);
    chk("ar_ready", 32'(reqReady4), 1);
    @(negedge clk);
    rst_n = 1'b1;
    mode4 = 1'b1; reqValid4 = 1'b1;
    tick();
    reqValid4 = 1'b0;
    chk("ar_restart_out",  32'(out4),      0);
    chk("ar_restart_chan", 32'(outChan4),  0);
    chk("ar_restart_vld",  32'(outValid4), 1);
    tick();
    chk("ar_restart_ch1",  32'(out4),      1);
    tick();
    tick();
    tick();
    chk("ar_restart_end",  32'(outValid4), 0);

    // ---------------- 3-channel x 8-bit instance ----------------
    outReady3 = 1'b1; mode3 = 1'b0; sel3 = 2'd1; reqValid3 = 1'b1;
    tick();
    reqValid3 = 1'b0;
    $display("txn c3 direct sel=1 out=%0h chan=%0d", out3, outChan3);
    chk("c3_d1_out",    32'(out3),    32'h0B2);
    chk("c3_d1_chan",   32'(outChan3), 1);
    chk("c3_d1_selerr", 32'(selErr3),  0);
    tick();
    sel3 = 2'd3; reqValid3 = 1'b1;
    tick();
    reqValid3 = 1'b0;
    $display("txn c3 direct sel=3 out=%0h chan=%0d err=%0d", out3, outChan3, selErr3);
    chk("c3_oor_out",    32'(out3),      0);
    chk("c3_oor_chan",   32'(outChan3),  3);
    chk("c3_oor_valid",  32'(outValid3), 1);
    chk("c3_oor_selerr", 32'(selErr3),   1);
    tick();
    sel3 = 2'd0; reqValid3 = 1'b1;
    tick();
    reqValid3 = 1'b0;
    $display("txn c3 direct sel=0 out=%0h chan=%0d", out3, outChan3);
    chk("c3_d0_out",     32'(out3),    32'h0A1);
    chk("c3_d0_selerr",  32'(selErr3), 1);
    tick();
    mode3 = 1'b1; reqValid3 = 1'b1;
    tick();
    reqValid3 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      $display("txn c3 scan beat=%0d out=%0h done=%0d", k, out3, done3);
      chk("c3_scan_out",  32'(out3),  32'(scan3Exp[k]));
      chk("c3_scan_done", 32'(done3), (k == 2) ? 1 : 0);
      tick();
    end
    chk("c3_scan_end",    32'(outValid3), 0);
    chk("c3_selerr_keep", 32'(selErr3),   1);

`ifdef MUX_ARR_PARITY_EN
    // ---------------- parity error on ch1 ----------------
    chk("par_clean4", 32'(parErr4), 0);
    chk("par_clean3", 32'(parErr3), 0);
    chk("par_outpar3", 32'(outPar3), 0);   // last beat C3 has even parity
    inPar4 = 4'b0100; mode4 = 1'b0; sel4 = 2'd1; reqValid4 = 1'b1; outReady4 = 1'b1;
    tick();
    reqValid4 = 1'b0;
    $display("txn parity sel=1 out=%0h par=%0d err=%0d", out4, outPar4, parErr4);
    chk("par_out",    32'(out4),    1);
    chk("par_outpar", 32'(outPar4), 1);
    chk("par_err",    32'(parErr4), 1);
    tick();
    chk("par_err_sticky", 32'(parErr4), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
